activation_unit: RTL and testbench

ACTIVATION_UNIT -- requirements
Module: activation_unit

---
 rtl/activation_unit.sv | 123 ++++++++++++
 tb/tb_activation_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/activation_unit.sv
// Two-stage valid/ready activation pipeline (step, ReLU, clipped ReLU, leaky ReLU)
// over CH signed fixed-point channels, with a saturating count of positive outputs.
module activation_unit #(
    parameter int W    = 10,
    parameter int FRAC = 4,
    parameter int CH   = 4,
    parameter int CLIP = 96
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CH*W-1:0] in_data,
    input  logic [1:0]      mode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CH*W-1:0] out_data,
    output logic [CH-1:0]   out_pos,
    input  logic            cnt_clr,
    output logic [15:0]     pos_count
);

    typedef enum logic [1:0] {
        MODE_STEP  = 2'b00,
        MODE_RELU  = 2'b01,
        MODE_CLIP  = 2'b10,
        MODE_LEAKY = 2'b11
    } mode_e;

    localparam logic signed [W-1:0] ONE_V  = W'(1 << FRAC);
    localparam logic signed [W-1:0] CLIP_V = W'(CLIP);

    logic            v1_q;
    logic [CH*W-1:0] s1Data_q;
    mode_e           s1Mode_q;
    logic            outValid_q;
    logic [CH*W-1:0] outData_q;
    logic [CH-1:0]   outPos_q;
    logic [15:0]     posCount_q;

    logic [CH*W-1:0] outData_d;
    logic [CH-1:0]   outPos_d;
    logic [15:0]     posCount_d;
    logic            adv1;
    logic            adv2;

    // Each stage moves when the stage after it is empty or draining this cycle.
    assign adv2      = !outValid_q || out_ready;
    assign adv1      = !v1_q || adv2;
    assign in_ready  = adv1;
    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_pos   = outPos_q;
    assign pos_count = posCount_q;

    always_comb begin
        logic signed [W-1:0] chIn;
        logic signed [W-1:0] chOut;
        logic                chPos;
        outData_d = '0;
        outPos_d  = '0;
        chIn      = '0;
        chOut     = '0;
        chPos     = 1'b0;
        for (int k = 0; k < CH; k++) begin
            chIn  = s1Data_q[k*W +: W];
            chPos = !chIn[W-1] && (chIn != '0);
            chOut = '0;
            case (s1Mode_q)
                MODE_STEP:  chOut = chPos ? ONE_V : '0;
                MODE_RELU:  chOut = chPos ? chIn : '0;
                MODE_CLIP:  chOut = chPos ? ((chIn > CLIP_V) ? CLIP_V : chIn) : '0;
                MODE_LEAKY: chOut = chIn[W-1] ? (chIn >>> 3) : chIn;
                default:    chOut = '0;
            endcase
            outData_d[k*W +: W] = chOut;
            outPos_d[k]         = chPos;
        end
    end

    // Counter update saturates rather than wrapping.
    always_comb begin
        logic [15:0] posSum;
        logic [16:0] sumWide;
        posSum = '0;
        for (int k = 0; k < CH; k++) begin
            posSum = posSum + 16'(outPos_q[k]);
        end
        sumWide    = {1'b0, posCount_q} + {1'b0, posSum};
        posCount_d = sumWide[16] ? 16'hFFFF : sumWide[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q       <= 1'b0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outPos_q   <= '0;
            posCount_q <= '0;
        end else begin
            if (adv1) begin
                v1_q <= in_valid;
                if (in_valid) begin
                    s1Data_q <= in_data;
                    s1Mode_q <= mode_e'(mode);
                end
            end
            if (adv2) begin
                outValid_q <= v1_q;
                if (v1_q) begin
                    outData_q <= outData_d;
                    outPos_q  <= outPos_d;
                end
            end
            if (cnt_clr) begin
                posCount_q <= '0;
            end else if (outValid_q && out_ready) begin
                posCount_q <= posCount_d;
            end
        end
    end

endmodule

// File: tb/tb_activation_unit.sv
// Self-checking bench for activation_unit: directed vector table, randomized
// backpressure stream against a queue-based reference model, counter and reset corners.
module tb_activation_unit;

    localparam int W    = 10;
    localparam int FRAC = 4;
    localparam int CH   = 4;
    localparam int CLIP = 96;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [CH*W-1:0] in_data;
    logic [1:0]      mode;
    logic            out_valid;
    logic            out_ready;
    logic [CH*W-1:0] out_data;
    logic [CH-1:0]   out_pos;
    logic            cnt_clr;
    logic [15:0]     pos_count;

    activation_unit #(.W(W), .FRAC(FRAC), .CH(CH), .CLIP(CLIP)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_pos(out_pos),
        .cnt_clr(cnt_clr), .pos_count(pos_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH*W-1:0] data;
        logic [CH-1:0]   pos;
        int              acc;
    } beat_t;

    typedef struct {
        logic [1:0] m;
        int         in0, in1, in2, in3;
        int         ex0, ex1, ex2, ex3;
        logic [3:0] pos;
    } vec_t;

    beat_t           expQ[$];
    vec_t            vecs[6];
    int              tests = 0;
    int              fails = 0;
    int              cyc = 0;
    int              modelCount = 0;
    int              acceptedCnt = 0;
    int              deliveredCnt = 0;
    logic            prevStall = 1'b0;
    logic [CH*W-1:0] prevData = '0;

    // Reference activation in plain integer arithmetic; leaky uses floor division by 8.
    function automatic int refAct(input int x, input logic [1:0] m);
        case (m)
            2'b00:   return (x > 0) ? (1 << FRAC) : 0;
            2'b01:   return (x > 0) ? x : 0;
            2'b10:   return (x > 0) ? ((x < CLIP) ? x : CLIP) : 0;
            default: return (x >= 0) ? x : -(((-x) + 7) / 8);
        endcase
    endfunction

    function automatic beat_t model(input logic [CH*W-1:0] d, input logic [1:0] m);
        beat_t               b;
        logic signed [W-1:0] s;
        int                  r;
        b.data = '0;
        b.pos  = '0;
        b.acc  = 0;
        for (int k = 0; k < CH; k++) begin
            s = d[k*W +: W];
            r = refAct(int'(s), m);
            b.data[k*W +: W] = r[W-1:0];
            b.pos[k]         = (int'(s) > 0);
        end
        return b;
    endfunction

    function automatic logic [CH*W-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [CH*W-1:0] r;
        r = '0;
        r[0*W +: W] = a[W-1:0];
        r[1*W +: W] = b[W-1:0];
        r[2*W +: W] = c[W-1:0];
        r[3*W +: W] = d[W-1:0];
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus; every cycle checks the DUT against the reference queue.
    task automatic applyStimulus(input logic v, input logic [CH*W-1:0] d, input logic [1:0] m,
                                 input logic rdy, input logic clr);
        logic  inX;
        logic  outX;
        logic  expValid;
        beat_t b;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        mode      = m;
        out_ready = rdy;
        cnt_clr   = clr;
        #1;
        expValid = 1'b0;
        if (expQ.size() > 0) expValid = (cyc >= expQ[0].acc + 2);
        checkOutput("pos_count", 64'(pos_count), 64'(modelCount));
        checkOutput("in_ready", 64'(in_ready), 64'(!(expQ.size() == 2 && !rdy)));
        checkOutput("out_valid", 64'(out_valid), 64'(expValid));
        if (prevStall) checkOutput("stall_hold", 64'(out_data), 64'(prevData));
        if (out_valid && expQ.size() > 0) begin
            checkOutput("out_data", 64'(out_data), 64'(expQ[0].data));
            checkOutput("out_pos", 64'(out_pos), 64'(expQ[0].pos));
        end
        outX = out_valid && rdy;
        inX  = v && in_ready;
        if (clr) begin
            modelCount = 0;
        end else if (outX && expQ.size() > 0) begin
            modelCount = modelCount + $countones(expQ[0].pos);
            if (modelCount > 65535) modelCount = 65535;
        end
        if (outX && expQ.size() > 0) begin
            void'(expQ.pop_front());
            deliveredCnt++;
        end
        if (inX) begin
            b     = model(d, m);
            b.acc = cyc;
            expQ.push_back(b);
            acceptedCnt++;
        end
        prevStall = out_valid && !rdy;
        prevData  = out_data;
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && expQ.size() > 0; i++) applyStimulus(1'b0, '0, 2'b00, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 2'b00, 1'b1, 1'b0);
        checkOutput("drain_empty", 64'(expQ.size()), 64'd0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        cnt_clr   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expQ.delete();
        modelCount = 0;
        prevStall  = 1'b0;
        cyc += 2;
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_pos_count", 64'(pos_count), 64'd0);
        checkOutput("rst_out_data", 64'(out_data), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [CH*W-1:0] allPos;
        logic [63:0]     rnd;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = 2'b00; out_ready = 1'b1; cnt_clr = 1'b0;

        vecs[0] = '{2'b01,   32, -16,  0, 511,   32,   0,  0, 511, 4'b1001};
        vecs[1] = '{2'b00,    1,   0, -1, 100,   16,   0,  0,  16, 4'b1001};
        vecs[2] = '{2'b10,  200,  96, 50,  -5,   96,  96, 50,   0, 4'b0111};
        vecs[3] = '{2'b11,  -16,  -1, -8,   7,   -2,  -1, -1,   7, 4'b1000};
        vecs[4] = '{2'b11,  511,-512,  0,   1,  511, -64,  0,   1, 4'b1001};
        vecs[5] = '{2'b01, -512,   1, -1,   0,    0,   1,  0,   0, 4'b0010};

        doReset();

        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, pack4(vecs[i].in0, vecs[i].in1, vecs[i].in2, vecs[i].in3), vecs[i].m, 1'b1, 1'b0);
            applyStimulus(1'b0, '0, 2'b00, 1'b1, 1'b0);
            applyStimulus(1'b0, '0, 2'b00, 1'b1, 1'b0);
            checkOutput("vec_valid", 64'(out_valid), 64'd1);
            checkOutput("vec_data", 64'(out_data),
                        64'(pack4(vecs[i].ex0, vecs[i].ex1, vecs[i].ex2, vecs[i].ex3)));
            checkOutput("vec_pos", 64'(out_pos), 64'(vecs[i].pos));
            if (i == 0) begin
                applyStimulus(1'b0, '0, 2'b00, 1'b1, 1'b0);
                checkOutput("relu_count", 64'(pos_count), 64'd2);
            end
        end
        drain();

        acceptedCnt  = 0;
        deliveredCnt = 0;
        for (int i = 0; i < 300; i++) begin
            rnd = {$urandom, $urandom};
            applyStimulus(($urandom_range(0, 9) < 7), rnd[CH*W-1:0], 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 1) == 1), ($urandom_range(0, 63) == 0));
        end
        drain();
        checkOutput("stream_min_beats", 64'(acceptedCnt >= 10), 64'd1);
        checkOutput("stream_delivered", 64'(deliveredCnt), 64'(acceptedCnt));

        doReset();
        allPos = pack4(1, 2, 3, 4);
        for (int i = 0; i < 16383; i++) applyStimulus(1'b1, allPos, 2'b01, 1'b1, 1'b0);
        applyStimulus(1'b1, pack4(5, 6, 0, -3), 2'b01, 1'b1, 1'b0);
        drain();
        checkOutput("sat_fffe", 64'(pos_count), 64'hFFFE);
        applyStimulus(1'b1, allPos, 2'b01, 1'b1, 1'b0);
        drain();
        checkOutput("sat_ffff", 64'(pos_count), 64'hFFFF);
        applyStimulus(1'b1, allPos, 2'b01, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 2'b00, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 2'b00, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 2'b00, 1'b1, 1'b0);
        checkOutput("clr_wins", 64'(pos_count), 64'd0);

        applyStimulus(1'b1, allPos, 2'b10, 1'b1, 1'b0);
        drain();
        applyStimulus(1'b1, pack4(7, 8, 9, 10), 2'b01, 1'b0, 1'b0);
        applyStimulus(1'b1, pack4(11, -12, 13, 14), 2'b11, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 2'b00, 1'b0, 1'b0);
        checkOutput("full_not_ready", 64'(in_ready), 64'd0);
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 2'b00, 1'b1, 1'b0);
        checkOutput("no_stale_count", 64'(pos_count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
